// File: rtl/mem_pkg.sv
// Shared memory-port definitions: access size codes and responder FSM state encodings.
package mem_pkg;

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_BYTE = 2'd1;
  localparam logic [1:0] SZ_HALF = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StAccess,
    StMerge,
    StResp,
    StErr
  } state_e;

endpackage

// File: rtl/mem_lane_sel.sv
// Byte-lane steering: merges sub-word store data into a word, sign-extends loads and
// flags misaligned or illegal-size accesses.
module mem_lane_sel
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] merged_o,
  output logic [31:0] load_o,
  output logic        misalign_o
);

  logic [4:0]  byte_off;
  logic [4:0]  half_off;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign byte_off = {lane_i, 3'b000};
  assign half_off = {lane_i[1], 4'b0000};
  assign sel_byte = word_i[byte_off +: 8];
  assign sel_half = word_i[half_off +: 16];

  always_comb begin
    merged_o   = word_i;
    load_o     = word_i;
    misalign_o = 1'b0;
    case (size_i)
      SZ_WORD: begin
        misalign_o = (lane_i != 2'b00);
        merged_o   = wdata_i;
      end
      SZ_BYTE: begin
        load_o                   = {{24{sel_byte[7]}}, sel_byte};
        merged_o[byte_off +: 8]  = wdata_i[7:0];
      end
      SZ_HALF: begin
        misalign_o               = lane_i[0];
        load_o                   = {{16{sel_half[15]}}, sel_half};
        merged_o[half_off +: 16] = wdata_i[15:0];
      end
      default: misalign_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Single-request memory responder with a done handshake; sub-word stores are
// read-modify-write through a one-word buffer.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [31:0]       mem_q [Depth];
  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [1:0]        lane_q, lane_d;
  logic [1:0]        size_q, size_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       buf_q, buf_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [1:0]        sel_lane;
  logic [1:0]        sel_size;
  logic [31:0]       merged;
  logic [31:0]       load_val;
  logic              misalign;
  logic              unused_addr;

  assign unused_addr = ^addr_i[31:ADDR_W+2];

  // In IDLE the alignment check looks at the live request, otherwise at the latched one.
  assign sel_lane = (state_q == StIdle) ? addr_i[1:0] : lane_q;
  assign sel_size = (state_q == StIdle) ? size_i : size_q;

  mem_lane_sel u_lane_sel (
    .word_i     (buf_q),
    .lane_i     (sel_lane),
    .size_i     (sel_size),
    .wdata_i    (wdata_q),
    .merged_o   (merged),
    .load_o     (load_val),
    .misalign_o (misalign)
  );

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    idx_d     = idx_q;
    lane_d    = lane_q;
    size_d    = size_q;
    wdata_d   = wdata_q;
    buf_d     = buf_q;
    rdata_d   = rdata_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = merged;
    unique case (state_q)
      StIdle: begin
        if (done_q) busy_d = 1'b0;
        if (req_i) begin
          we_d    = we_i;
          idx_d   = addr_i[ADDR_W+1:2];
          lane_d  = addr_i[1:0];
          size_d  = size_i;
          wdata_d = wdata_i;
          busy_d  = 1'b1;
          state_d = misalign ? StErr : StAccess;
        end
      end
      StAccess: begin
        buf_d = mem_q[idx_q];
        if (we_q && (size_q == SZ_WORD)) begin
          mem_we    = 1'b1;
          mem_wdata = wdata_q;
          state_d   = StResp;
        end else if (we_q) begin
          state_d = StMerge;
        end else begin
          state_d = StResp;
        end
      end
      StMerge: begin
        mem_we  = 1'b1;
        state_d = StResp;
      end
      StResp: begin
        done_d  = 1'b1;
        if (!we_q) rdata_d = load_val;
        state_d = StIdle;
      end
      StErr: begin
        done_d  = 1'b1;
        err_d   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      idx_q   <= '0;
      lane_q  <= 2'b00;
      size_q  <= SZ_WORD;
      wdata_q <= '0;
      buf_q   <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Write enable derives from state_q, so an asynchronous reset cancels a pending commit.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[idx_q] <= mem_wdata;
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: latency, lane steering, errors, held req and reset abort.
module tb_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [1:0]  size;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        err;

  int vectors = 0;
  int miscompares = 0;

  mem_responder #(.ADDR_W(8)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .req_i   (req),
    .we_i    (we),
    .addr_i  (addr),
    .size_i  (size),
    .wdata_i (wdata),
    .busy_o  (busy),
    .done_o  (done),
    .rdata_o (rdata),
    .err_o   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait (bounded) for done, check latency/err/rdata and the idle return.
  task automatic run(input logic w, input logic [31:0] a, input logic [1:0] s,
                     input logic [31:0] d, input int exp_lat, input logic exp_err,
                     input logic chk_rd, input logic [31:0] exp_rd, input string tag);
    int lat;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; size = s; wdata = d;
    @(posedge clk);
    #1 req = 1'b0;
    lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(negedge clk);
      if (i == 1) chk({31'd0, busy}, 32'd1, {tag, "/busy"});
      if (done) lat = i;
    end
    chk(lat, exp_lat, {tag, "/lat"});
    chk({31'd0, err}, {31'd0, exp_err}, {tag, "/err"});
    if (chk_rd) chk(rdata, exp_rd, {tag, "/rdata"});
    @(negedge clk);
    chk({30'd0, busy, done}, 32'd0, {tag, "/idle"});
  endtask

  initial begin
    int ndone;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; size = 2'd0; wdata = '0;
    #12;
    chk({29'd0, busy, done, err}, 32'd0, "rst/flags");
    chk(rdata, 32'd0, "rst/rdata");
    @(negedge clk);
    rst_n = 1'b1;

    run(1'b1, 32'h10, 2'd0, 32'hDEADBEEF, 3, 1'b0, 1'b0, 32'h0, "sw10");
    run(1'b0, 32'h10, 2'd0, 32'h0,        3, 1'b0, 1'b1, 32'hDEADBEEF, "lw10a");
    run(1'b1, 32'h11, 2'd1, 32'h0000007F, 4, 1'b0, 1'b0, 32'h0, "sb11");
    run(1'b0, 32'h10, 2'd0, 32'h0,        3, 1'b0, 1'b1, 32'hDEAD7FEF, "lw10b");
    run(1'b1, 32'h12, 2'd2, 32'h00008001, 4, 1'b0, 1'b0, 32'h0, "sh12");
    run(1'b0, 32'h12, 2'd2, 32'h0,        3, 1'b0, 1'b1, 32'hFFFF8001, "lh12");
    run(1'b0, 32'h10, 2'd1, 32'h0,        3, 1'b0, 1'b1, 32'hFFFFFFEF, "lb10");
    run(1'b0, 32'h13, 2'd2, 32'h0,        2, 1'b1, 1'b1, 32'hFFFFFFEF, "lh13err");
    run(1'b1, 32'h12, 2'd0, 32'h12345678, 2, 1'b1, 1'b1, 32'hFFFFFFEF, "sw12err");
    run(1'b0, 32'h10, 2'd3, 32'h0,        2, 1'b1, 1'b1, 32'hFFFFFFEF, "sz3err");
    run(1'b0, 32'h10, 2'd0, 32'h0,        3, 1'b0, 1'b1, 32'h80017FEF, "lw10c");
    run(1'b0, 32'h13, 2'd1, 32'h0,        3, 1'b0, 1'b1, 32'hFFFFFF80, "lb13");
    run(1'b0, 32'h10, 2'd2, 32'h0,        3, 1'b0, 1'b1, 32'h00007FEF, "lh10");

    // req held through the busy window of one SW: only one done must appear.
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h30; size = 2'd0; wdata = 32'hCAFEF00D;
    ndone = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 2) req = 1'b0;
      if (done) ndone++;
    end
    chk(ndone, 32'd1, "held/ndone");
    run(1'b0, 32'h30, 2'd0, 32'h0, 3, 1'b0, 1'b1, 32'hCAFEF00D, "lw30");

    // Reset during MERGE of an SB must discard the merged write.
    run(1'b1, 32'h20, 2'd0, 32'h11223344, 3, 1'b0, 1'b0, 32'h0, "sw20");
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; size = 2'd1; wdata = 32'h000000AA;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk({29'd0, busy, done, err}, 32'd0, "abort/flags");
    chk(rdata, 32'd0, "abort/rdata");
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk(ndone, 32'd0, "abort/nodone");
    run(1'b0, 32'h20, 2'd0, 32'h0, 3, 1'b0, 1'b1, 32'h11223344, "lw20");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
